// File: rtl/hdng_integrator_pkg.sv
// Shared widths and FSM state encoding for the heading integrator slice.
package hdng_pkg;

    localparam int HDNG_W = 12;
    localparam int YAW_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAL  = 2'd1,
        ST_RUN  = 2'd2
    } hdng_state_t;

endpackage

// File: rtl/hdng_integrator_if.sv
// Gyro sample input and heading output bundle between the sensor front-end and the PID.
interface hdng_integrator_if;
    import hdng_pkg::*;

    logic                     strt_cal;
    logic                     yaw_vld;
    logic signed [YAW_W-1:0]  yaw_rt;
    logic [HDNG_W-1:0]        actl_hdng;
    logic                     hdng_vld;
    logic                     cal_done;
    logic                     rdy;

    modport master (
        output strt_cal, yaw_vld, yaw_rt,
        input  actl_hdng, hdng_vld, cal_done, rdy
    );

    modport slave (
        input  strt_cal, yaw_vld, yaw_rt,
        output actl_hdng, hdng_vld, cal_done, rdy
    );

endinterface

// File: rtl/hdng_integrator_cal_avg.sv
// Gyro zero-rate offset estimator: averages 2^CAL_LOG2 samples with a floor divide.
module cal_avg
    import hdng_pkg::*;
#(
    parameter int CAL_LOG2 = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    smpl_vld,
    input  logic signed [YAW_W-1:0] yaw_rt,
    output logic                    last,
    output logic signed [YAW_W-1:0] offset
);

    localparam int SUM_W = YAW_W + CAL_LOG2;

    logic [CAL_LOG2-1:0]     cnt;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] sum_nxt;

    assign sum_nxt = sum + SUM_W'(yaw_rt);
    assign last    = smpl_vld && (&cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            sum    <= '0;
            offset <= '0;
        end else if (clr) begin
            cnt <= '0;
            sum <= '0;
        end else if (smpl_vld) begin
            cnt <= cnt + 1'b1;
            sum <= sum_nxt;
            // taking the upper bits of a two's-complement sum is an arithmetic floor divide
            if (last)
                offset <= sum_nxt[SUM_W-1:CAL_LOG2];
        end
    end

endmodule

// File: rtl/hdng_integrator.sv
// Integrates offset-corrected gyro yaw rate into a 12-bit compass heading.
//   state   | meaning
//   IDLE    | after reset, samples ignored until a calibration is requested
//   CAL     | accumulating samples to estimate the zero-rate offset
//   RUN     | integrating (yaw_rt - offset) into the heading, rdy high
module hdng_integrator
    import hdng_pkg::*;
#(
    parameter int CAL_LOG2  = 11,
    parameter int HDNG_SHFT = 11
) (
    input  logic               clk,
    input  logic               rst,
    hdng_integrator_if.slave   bus
);

    localparam int ACC_W = HDNG_W + HDNG_SHFT;
    localparam int EXT_W = (ACC_W > YAW_W + 1) ? ACC_W : YAW_W + 1;

    hdng_state_t               state;
    logic [ACC_W-1:0]          hacc;
    logic                      cal_smpl;
    logic                      cal_last;
    logic signed [YAW_W-1:0]   offset;
    logic signed [YAW_W:0]     diff;
    logic signed [EXT_W-1:0]   diff_ext;

    assign cal_smpl = (state == ST_CAL) && bus.yaw_vld && !bus.strt_cal;
    assign diff     = {bus.yaw_rt[YAW_W-1], bus.yaw_rt} - {offset[YAW_W-1], offset};
    assign diff_ext = EXT_W'(diff);

    cal_avg #(
        .CAL_LOG2 (CAL_LOG2)
    ) u_cal_avg (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.strt_cal),
        .smpl_vld (cal_smpl),
        .yaw_rt   (bus.yaw_rt),
        .last     (cal_last),
        .offset   (offset)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            hacc         <= '0;
            bus.hdng_vld <= 1'b0;
            bus.cal_done <= 1'b0;
            bus.rdy      <= 1'b0;
        end else begin
            bus.hdng_vld <= 1'b0;
            bus.cal_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.strt_cal)
                        state <= ST_CAL;
                end
                ST_CAL: begin
                    if (cal_last) begin
                        state        <= ST_RUN;
                        bus.cal_done <= 1'b1;
                        bus.rdy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // recalibration keeps the heading; old offset stays until the new one lands
                    if (bus.strt_cal) begin
                        state   <= ST_CAL;
                        bus.rdy <= 1'b0;
                    end else if (bus.yaw_vld) begin
                        hacc         <= hacc + diff_ext[ACC_W-1:0];
                        bus.hdng_vld <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bus.rdy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.actl_hdng = hacc[ACC_W-1:HDNG_SHFT];

endmodule

// File: tb/tb_hdng_integrator.sv
// Directed bench for hdng_integrator with CAL_LOG2=2, HDNG_SHFT=4.
module tb_hdng_integrator;
    import hdng_pkg::*;

    typedef struct {
        logic        strt;
        logic        vld;
        logic [15:0] yaw;
        logic [11:0] e_hdng;
        logic        e_vld;
        logic        e_cd;
        logic        e_rdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    hdng_integrator_if bus ();

    hdng_integrator #(
        .CAL_LOG2  (2),
        .HDNG_SHFT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    vec_t vecs[$];

    task automatic drive(input logic s, input logic v, input logic [15:0] y);
        bus.strt_cal = s;
        bus.yaw_vld  = v;
        bus.yaw_rt   = y;
        @(negedge clk);
        bus.strt_cal = 1'b0;
        bus.yaw_vld  = 1'b0;
        bus.yaw_rt   = 16'h0;
    endtask

    task automatic check(input string name, input logic [11:0] h, input logic v,
                         input logic cd, input logic r);
        n_vec++;
        if (bus.actl_hdng !== h || bus.hdng_vld !== v || bus.cal_done !== cd || bus.rdy !== r) begin
            n_err++;
            $display("FAIL %s: got hdng=%h vld=%b cal_done=%b rdy=%b, want hdng=%h vld=%b cal_done=%b rdy=%b",
                     name, bus.actl_hdng, bus.hdng_vld, bus.cal_done, bus.rdy, h, v, cd, r);
        end
    endtask

    task automatic check_off(input string name, input logic [15:0] e);
        n_vec++;
        if (dut.u_cal_avg.offset !== e) begin
            n_err++;
            $display("FAIL %s: got offset=%0d want %0d", name,
                     $signed(dut.u_cal_avg.offset), $signed(e));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.strt_cal = 1'b1;
        bus.yaw_vld  = 1'b1;
        bus.yaw_rt   = 16'd77;
        @(negedge clk);
        rst = 1'b0;
        bus.strt_cal = 1'b0;
        bus.yaw_vld  = 1'b0;
        bus.yaw_rt   = 16'h0;
    endtask

    task automatic cal4(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d, input logic [11:0] h);
        drive(1'b1, 1'b0, 16'h0);
        drive(1'b0, 1'b1, a); check({name, "_s1"}, h, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, b);
        drive(1'b0, 1'b1, c); check({name, "_s3"}, h, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, d); check({name, "_done"}, h, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        bus.strt_cal = 1'b0;
        bus.yaw_vld  = 1'b0;
        bus.yaw_rt   = 16'h0;

        vecs.push_back('{1'b0, 1'b1, 16'd100,  12'h000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, -16'sd50, 12'h000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'd0,    12'h000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 16'd10,   12'h000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 16'd12,   12'h000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 16'd14,   12'h000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 16'd16,   12'h000, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 16'd0,    12'h000, 1'b0, 1'b0, 1'b1});
        for (int k = 1; k <= 16; k++)
            vecs.push_back('{1'b0, 1'b1, 16'd29, 12'(k), 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 16'd0,    12'h010, 1'b0, 1'b0, 1'b1});

        @(negedge clk);
        do_reset();
        check("reset", 12'h000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].strt, vecs[i].vld, vecs[i].yaw);
            check($sformatf("vec%0d", i), vecs[i].e_hdng, vecs[i].e_vld, vecs[i].e_cd, vecs[i].e_rdy);
        end
        check_off("offset_13", 16'd13);

        // wrap below zero and back, from a freshly reset heading
        do_reset();
        cal4("cal13", 16'd10, 16'd12, 16'd14, 16'd16, 12'h000);
        drive(1'b0, 1'b1, -16'sd3); check("wrap_fff", 12'hFFF, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 16'd29);  check("wrap_000", 12'h000, 1'b1, 1'b0, 1'b1);

        // recal from RUN with a coincident sample: no hdng_vld, heading held
        drive(1'b1, 1'b1, 16'd500); check("recal_run", 12'h000, 1'b0, 1'b0, 1'b0);
        check_off("offset_kept", 16'd13);
        drive(1'b0, 1'b1, -16'sd1);
        drive(1'b0, 1'b1, -16'sd2);
        drive(1'b0, 1'b1, -16'sd2); check("negcal_s3", 12'h000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, -16'sd2); check("negcal_done", 12'h000, 1'b0, 1'b1, 1'b1);
        check_off("offset_floor", -16'sd2);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, -16'sd2);
            check($sformatf("zero_rate%0d", k), 12'h000, 1'b1, 1'b0, 1'b1);
        end

        // restart mid-CAL: the two pre-restart samples must not count
        do_reset();
        drive(1'b1, 1'b0, 16'h0);
        drive(1'b0, 1'b1, 16'd100);
        drive(1'b0, 1'b1, 16'd100);
        drive(1'b1, 1'b1, 16'd100); check("restart", 12'h000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 16'd5);
        drive(1'b0, 1'b1, 16'd5);
        drive(1'b0, 1'b1, 16'd5);   check("restart_s3", 12'h000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 16'd5);   check("restart_done", 12'h000, 1'b0, 1'b1, 1'b1);
        check_off("offset_5", 16'd5);
        drive(1'b0, 1'b1, 16'd21);  check("run_after_restart", 12'h001, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 16'd21);

        // reset mid-RUN while a sample is in flight
        rst = 1'b1;
        drive(1'b1, 1'b1, 16'd21);
        rst = 1'b0;
        check("rst_run", 12'h000, 1'b0, 1'b0, 1'b0);
        check_off("offset_rst", 16'd0);
        drive(1'b0, 1'b1, 16'd300); check("post_rst_idle", 12'h000, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, want finish within 200000");
        $fatal(1);
    end

endmodule

// File: doc/hdng_integrator.md
HDNG_INTEGRATOR -- requirements
Module: hdng_integrator

Interface
REQ-001 Parameter CAL_LOG2, default 11: log2 of the number of yaw samples averaged during calibration.
REQ-002 Parameter HDNG_SHFT, default 11: fractional bits below actl_hdng in the heading accumulator.
REQ-003 Ports: clk, input, 1, sole clock, all logic on rising edge.
REQ-004 Ports: rst, input, 1, synchronous, active-high reset.
REQ-005 Ports: strt_cal, input, 1, single-cycle request to (re)start offset calibration.
REQ-006 Ports: yaw_vld, input, 1, single-cycle strobe qualifying yaw_rt.
REQ-007 Ports: yaw_rt, input, 16, signed raw gyro yaw-rate sample.
REQ-008 Ports: actl_hdng, output, 12, integrated heading (0x000 N, 0x3FF W, 0x7FF S, 0xBFF E), feeds PID actl_hdng.
REQ-009 Ports: hdng_vld, output, 1, one-cycle pulse marking a new actl_hdng, feeds PID hdng_vld.
REQ-010 Ports: cal_done, output, 1, one-cycle pulse at calibration completion.
REQ-011 Ports: rdy, output, 1, high while in RUN.

Function
REQ-012 FSM states: IDLE, CAL, RUN.
REQ-013 IDLE: yaw_vld ignored; strt_cal -> CAL next cycle, clear sample counter and cal sum.
REQ-014 CAL: each yaw_vld adds sign-extended yaw_rt into a (16+CAL_LOG2)-bit signed sum and increments counter.
REQ-015 CAL: on the yaw_vld that completes sample 2^CAL_LOG2, next cycle: offset <= sum >>> CAL_LOG2 (arithmetic, floor), cal_done=1 for one cycle, state -> RUN.
REQ-016 strt_cal during CAL: counter and sum cleared, calibration restarts; that cycle's yaw_vld sample discarded.
REQ-017 RUN: each yaw_vld adds (yaw_rt - offset), computed 17-bit signed, sign-extended, into a (12+HDNG_SHFT)-bit heading accumulator, modulo 2^(12+HDNG_SHFT).
REQ-018 actl_hdng = heading accumulator[top 12 bits]; wraps 0xFFF<->0x000 naturally, no saturation.
REQ-019 Latency: hdng_vld pulses exactly one cycle after each accepted RUN yaw_vld; actl_hdng reflects that sample in the same cycle and holds until the next update.
REQ-020 hdng_vld never asserted outside RUN; back-to-back yaw_vld in RUN yields back-to-back hdng_vld.
REQ-021 strt_cal in RUN: -> CAL, heading accumulator held (not cleared), offset kept until new cal completes; that cycle's yaw_vld discarded, no hdng_vld.
REQ-022 Offset register only written at cal completion.

Reset
REQ-023 rst: state IDLE; offset, both accumulators, counter = 0; actl_hdng=0x000, hdng_vld=0, cal_done=0, rdy=0 on the cycle after rst sampled high.
REQ-024 rst overrides strt_cal and yaw_vld in the same cycle; reset mid-CAL or mid-RUN discards all progress.

Structure
REQ-025 Package hdng_pkg holds HDNG_W=12, YAW_W=16 and the FSM state enum.
REQ-026 Averaging logic (counter, sum, offset divide) lives in sub-module cal_avg; FSM and heading accumulator live in hdng_integrator.

Verification (bench uses CAL_LOG2=2, HDNG_SHFT=4)
REQ-027 Reset, then yaw_vld pulses with no strt_cal -> hdng_vld stays 0, actl_hdng=0x000, rdy=0.
REQ-028 strt_cal, samples 10,12,14,16 -> cal_done pulse one cycle after 4th sample, offset=13, rdy=1.
REQ-029 After REQ-028, yaw_rt=29 -> next cycle hdng_vld=1, actl_hdng=0x001; 15 more such samples -> actl_hdng=0x010.
REQ-030 From fresh cal offset 13, yaw_rt=-3 once -> actl_hdng=0xFFF (wrap); then yaw_rt=29 -> 0x000.
REQ-031 Cal samples -1,-2,-2,-2 -> offset=-2 (floor); yaw_rt=-2 repeatedly -> actl_hdng unchanged, hdng_vld pulses each sample.
REQ-032 strt_cal mid-CAL after 2 samples and rst mid-RUN -> cal completes only after 4 fresh samples; after rst all outputs zero.
